// File: rtl/repl_pkg.sv
// Shared types and helpers for the refill victim allocator.
// Helpers work on a fixed max width; callers zero-extend and truncate.
package repl_pkg;

  localparam int REPL_MAX_ENTRIES = 256;
  localparam int REPL_MAX_IDX_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHOOSE = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } repl_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [REPL_MAX_ENTRIES-1:0] onehot_lowest(
      input logic [REPL_MAX_ENTRIES-1:0] vec);
    return vec & (~vec + 1'b1);
  endfunction

  function automatic logic [REPL_MAX_IDX_W-1:0] onehot_to_idx(
      input logic [REPL_MAX_ENTRIES-1:0] vec);
    logic [REPL_MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REPL_MAX_ENTRIES; i++)
      if (vec[i]) idx = idx | REPL_MAX_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/repl_victim_alloc_if.sv
// Refill request/completion, PLRU feedback and entry write port bundle.
interface repl_victim_alloc_if #(
    parameter int ENTRY_COUNT = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int IDX_W       = 2
);
    logic                   refill_req_valid_i;
    logic                   refill_req_ready_o;
    logic [DATA_WIDTH-1:0]  refill_req_data_i;
    logic                   flush_i;
    logic [ENTRY_COUNT-1:0] entry_valid_i;
    logic [ENTRY_COUNT-1:0] entry_lock_i;
    logic [ENTRY_COUNT-1:0] plru_lru_mask_i;
    logic [ENTRY_COUNT-1:0] lookup_hit_mask_i;
    logic [ENTRY_COUNT-1:0] plru_access_mask_o;
    logic                   lookup_stall_o;
    logic                   wr_en_o;
    logic [ENTRY_COUNT-1:0] wr_mask_o;
    logic [IDX_W-1:0]       wr_idx_o;
    logic [DATA_WIDTH-1:0]  wr_data_o;
    logic                   refill_done_valid_o;
    logic                   refill_done_ready_i;
    logic                   refill_done_err_o;

    modport slave (
        input  refill_req_valid_i, refill_req_data_i, flush_i, entry_valid_i,
               entry_lock_i, plru_lru_mask_i, lookup_hit_mask_i, refill_done_ready_i,
        output refill_req_ready_o, plru_access_mask_o, lookup_stall_o, wr_en_o,
               wr_mask_o, wr_idx_o, wr_data_o, refill_done_valid_o, refill_done_err_o
    );

    modport master (
        output refill_req_valid_i, refill_req_data_i, flush_i, entry_valid_i,
               entry_lock_i, plru_lru_mask_i, lookup_hit_mask_i, refill_done_ready_i,
        input  refill_req_ready_o, plru_access_mask_o, lookup_stall_o, wr_en_o,
               wr_mask_o, wr_idx_o, wr_data_o, refill_done_valid_o, refill_done_err_o
    );
endinterface

// File: rtl/repl_victim_alloc_victim_pick.sv
// Combinational victim selection: free entry first, then PLRU choice,
// then any unlocked entry; all-locked reports an error.
module victim_pick
    import repl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] valid,
    input  logic [N-1:0] lock,
    input  logic [N-1:0] lru,
    output logic [N-1:0] victim,
    output logic         err
);
    logic [N-1:0] cand;
    logic [N-1:0] free;

    always_comb begin
        cand   = ~lock;
        free   = ~valid & cand;
        victim = '0;
        err    = 1'b0;
        if (|free)
            victim = N'(onehot_lowest(REPL_MAX_ENTRIES'(free)));
        else if (|(lru & cand))
            victim = lru;
        else if (|cand)
            victim = N'(onehot_lowest(REPL_MAX_ENTRIES'(cand)));
        else
            err = 1'b1;
    end
endmodule

// File: rtl/repl_victim_alloc.sv
// Refill allocation FSM: accept, choose victim, single-cycle write, respond.
// Also merges lookup hits and the refill write into the PLRU access mask.
module repl_victim_alloc
    import repl_pkg::*;
#(
    parameter int ENTRY_COUNT = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int IDX_W       = idx_w(ENTRY_COUNT)
) (
    input logic                clk,
    input logic                rstn,
    repl_victim_alloc_if.slave bus
);
    repl_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [ENTRY_COUNT-1:0] victim_q;
    logic                   err_q;
    logic [ENTRY_COUNT-1:0] pick_victim;
    logic                   pick_err;
    logic                   accept;

    victim_pick #(.N(ENTRY_COUNT)) u_pick (
        .valid  (bus.entry_valid_i),
        .lock   (bus.entry_lock_i),
        .lru    (bus.plru_lru_mask_i),
        .victim (pick_victim),
        .err    (pick_err)
    );

    always_comb begin
        state_d                 = state_q;
        accept                  = 1'b0;
        bus.refill_req_ready_o  = 1'b0;
        bus.plru_access_mask_o  = bus.lookup_hit_mask_i;
        bus.lookup_stall_o      = 1'b0;
        bus.wr_en_o             = 1'b0;
        bus.wr_mask_o           = '0;
        bus.wr_idx_o            = '0;
        bus.wr_data_o           = '0;
        bus.refill_done_valid_o = 1'b0;
        bus.refill_done_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.refill_req_ready_o = !bus.flush_i;
                accept = bus.refill_req_valid_i && !bus.flush_i;
                if (accept) state_d = CHOOSE;
            end
            CHOOSE: begin
                if (bus.flush_i)   state_d = IDLE;
                else if (pick_err) state_d = RESP;
                else               state_d = WRITE;
            end
            WRITE: begin
                // The write commits regardless of flush; hits are masked so
                // the PLRU sees only the refilled entry this cycle.
                bus.wr_en_o            = 1'b1;
                bus.wr_mask_o          = victim_q;
                bus.wr_idx_o           = IDX_W'(onehot_to_idx(REPL_MAX_ENTRIES'(victim_q)));
                bus.wr_data_o          = data_q;
                bus.plru_access_mask_o = victim_q;
                bus.lookup_stall_o     = 1'b1;
                state_d                = RESP;
            end
            RESP: begin
                bus.refill_done_valid_o = 1'b1;
                bus.refill_done_err_o   = err_q;
                if (bus.refill_done_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            victim_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) data_q <= bus.refill_req_data_i;
            if (state_q == CHOOSE) begin
                victim_q <= pick_victim;
                err_q    <= pick_err;
            end
        end
    end
endmodule

// File: tb/tb_repl_victim_alloc.sv
// Directed bench for repl_victim_alloc with ENTRY_COUNT=4, DATA_WIDTH=64.
module tb_repl_victim_alloc;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    repl_victim_alloc_if #(.ENTRY_COUNT(4), .DATA_WIDTH(64), .IDX_W(2)) bus ();

    repl_victim_alloc #(.ENTRY_COUNT(4), .DATA_WIDTH(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [3:0] v, input logic [3:0] l, input logic [3:0] lru);
        bus.entry_valid_i   = v;
        bus.entry_lock_i    = l;
        bus.plru_lru_mask_i = lru;
    endtask

    // Full refill from IDLE back to IDLE; req_data is changed after acceptance.
    task automatic refill(input string tag, input logic [63:0] d, input logic [3:0] hit,
                          input logic [3:0] exp_mask, input logic [1:0] exp_idx,
                          input logic exp_err);
        bus.lookup_hit_mask_i  = hit;
        bus.refill_req_valid_i = 1'b1;
        bus.refill_req_data_i  = d;
        #1;
        chk({tag, ".idle_ready"}, 64'(bus.refill_req_ready_o), 64'd1);
        chk({tag, ".idle_access"}, 64'(bus.plru_access_mask_o), 64'(hit));
        step();
        bus.refill_req_valid_i = 1'b0;
        bus.refill_req_data_i  = ~d;
        #1;
        chk({tag, ".choose_wr_en"}, 64'(bus.wr_en_o), 64'd0);
        chk({tag, ".choose_access"}, 64'(bus.plru_access_mask_o), 64'(hit));
        chk({tag, ".choose_stall"}, 64'(bus.lookup_stall_o), 64'd0);
        step();
        if (!exp_err) begin
            chk({tag, ".wr_en"}, 64'(bus.wr_en_o), 64'd1);
            chk({tag, ".wr_mask"}, 64'(bus.wr_mask_o), 64'(exp_mask));
            chk({tag, ".wr_idx"}, 64'(bus.wr_idx_o), 64'(exp_idx));
            chk({tag, ".wr_data"}, bus.wr_data_o, d);
            chk({tag, ".wr_access"}, 64'(bus.plru_access_mask_o), 64'(exp_mask));
            chk({tag, ".wr_stall"}, 64'(bus.lookup_stall_o), 64'd1);
            chk({tag, ".wr_done_valid"}, 64'(bus.refill_done_valid_o), 64'd0);
            step();
        end
        chk({tag, ".resp_valid"}, 64'(bus.refill_done_valid_o), 64'd1);
        chk({tag, ".resp_err"}, 64'(bus.refill_done_err_o), 64'(exp_err));
        chk({tag, ".resp_wr_en"}, 64'(bus.wr_en_o), 64'd0);
        chk({tag, ".resp_ready"}, 64'(bus.refill_req_ready_o), 64'd0);
        chk({tag, ".resp_access"}, 64'(bus.plru_access_mask_o), 64'(hit));
        chk({tag, ".resp_stall"}, 64'(bus.lookup_stall_o), 64'd0);
        bus.refill_done_ready_i = 1'b1;
        step();
        bus.refill_done_ready_i = 1'b0;
        #1;
        chk({tag, ".post_valid"}, 64'(bus.refill_done_valid_o), 64'd0);
        chk({tag, ".post_ready"}, 64'(bus.refill_req_ready_o), 64'd1);
    endtask

    initial begin
        bus.refill_req_valid_i  = 1'b0;
        bus.refill_req_data_i   = '0;
        bus.flush_i             = 1'b0;
        bus.refill_done_ready_i = 1'b0;
        bus.lookup_hit_mask_i   = '0;
        setup(4'b0000, 4'b0000, 4'b0001);
        step();
        step();
        rstn = 1'b1;
        #1;
        chk("rst.ready", 64'(bus.refill_req_ready_o), 64'd1);
        chk("rst.wr_en", 64'(bus.wr_en_o), 64'd0);
        chk("rst.wr_mask", 64'(bus.wr_mask_o), 64'd0);
        chk("rst.wr_idx", 64'(bus.wr_idx_o), 64'd0);
        chk("rst.wr_data", bus.wr_data_o, 64'd0);
        chk("rst.done_valid", 64'(bus.refill_done_valid_o), 64'd0);
        chk("rst.err", 64'(bus.refill_done_err_o), 64'd0);
        chk("rst.stall", 64'(bus.lookup_stall_o), 64'd0);
        chk("rst.access", 64'(bus.plru_access_mask_o), 64'd0);

        // Invalid entry preferred over PLRU choice.
        setup(4'b1011, 4'b0000, 4'b0001);
        refill("inv", 64'h1111_2222_3333_4444, 4'b0000, 4'b0100, 2'd2, 1'b0);
        // All valid: PLRU choice, payload latched (back-to-back request).
        setup(4'b1111, 4'b0000, 4'b1000);
        refill("lru", 64'hDEAD_BEEF_0000_0001, 4'b0000, 4'b1000, 2'd3, 1'b0);
        // PLRU entry locked: fall back to lowest unlocked.
        setup(4'b1111, 4'b1000, 4'b1000);
        refill("lockfb", 64'hA5A5_A5A5_5A5A_5A5A, 4'b0000, 4'b0001, 2'd0, 1'b0);
        // Only invalid entry is locked: PLRU choice wins.
        setup(4'b1110, 4'b0001, 4'b0100);
        refill("invlock", 64'h0123_4567_89AB_CDEF, 4'b0000, 4'b0100, 2'd2, 1'b0);
        // Lookup hits held through refill.
        setup(4'b1111, 4'b0001, 4'b0010);
        refill("hit", 64'hCAFE_F00D_0000_0002, 4'b0010, 4'b0010, 2'd1, 1'b0);
        // Everything locked: error, no write, done at T+2.
        setup(4'b1111, 4'b1111, 4'b1000);
        refill("allock", 64'hFFFF_0000_FFFF_0000, 4'b0000, 4'b0000, 2'd0, 1'b1);

        // Flush blocks acceptance in IDLE and aborts in CHOOSE.
        setup(4'b1111, 4'b0000, 4'b0010);
        bus.lookup_hit_mask_i = '0;
        bus.flush_i = 1'b1;
        #1;
        chk("flush.idle_ready", 64'(bus.refill_req_ready_o), 64'd0);
        bus.flush_i = 1'b0;
        bus.refill_req_valid_i = 1'b1;
        bus.refill_req_data_i  = 64'h5555_5555_5555_5555;
        step();
        bus.refill_req_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        #1;
        chk("flush.ready_back", 64'(bus.refill_req_ready_o), 64'd1);
        chk("flush.no_wr", 64'(bus.wr_en_o), 64'd0);
        chk("flush.no_done", 64'(bus.refill_done_valid_o), 64'd0);
        step();
        chk("flush.no_wr2", 64'(bus.wr_en_o), 64'd0);
        chk("flush.no_done2", 64'(bus.refill_done_valid_o), 64'd0);

        // Flush during WRITE is ignored.
        bus.refill_req_valid_i = 1'b1;
        bus.refill_req_data_i  = 64'h7777_0000_7777_0000;
        step();
        bus.refill_req_valid_i = 1'b0;
        step();
        bus.flush_i = 1'b1;
        #1;
        chk("flushwr.wr_en", 64'(bus.wr_en_o), 64'd1);
        chk("flushwr.wr_mask", 64'(bus.wr_mask_o), 64'h2);
        chk("flushwr.wr_data", bus.wr_data_o, 64'h7777_0000_7777_0000);
        step();
        chk("flushwr.done", 64'(bus.refill_done_valid_o), 64'd1);
        chk("flushwr.err", 64'(bus.refill_done_err_o), 64'd0);
        bus.flush_i = 1'b0;
        bus.refill_done_ready_i = 1'b1;
        step();
        bus.refill_done_ready_i = 1'b0;

        // Completion back-pressure with error held stable.
        setup(4'b1111, 4'b1111, 4'b0001);
        bus.refill_req_valid_i = 1'b1;
        step();
        bus.refill_req_valid_i = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 64'(bus.refill_done_valid_o), 64'd1);
            chk("hold.err", 64'(bus.refill_done_err_o), 64'd1);
            chk("hold.ready", 64'(bus.refill_req_ready_o), 64'd0);
            step();
        end

        // Reset while in RESP.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        chk("rstresp.valid", 64'(bus.refill_done_valid_o), 64'd0);
        chk("rstresp.err", 64'(bus.refill_done_err_o), 64'd0);
        chk("rstresp.ready", 64'(bus.refill_req_ready_o), 64'd1);
        chk("rstresp.wr_en", 64'(bus.wr_en_o), 64'd0);
        step();
        chk("rstresp.no_stale", 64'(bus.refill_done_valid_o), 64'd0);
        step();
        chk("rstresp.no_stale2", 64'(bus.refill_done_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
